// File: rtl/conv_out_writer_if.sv
// Stream-in / SRAM-write-out bundle for conv_out_writer.
// Master drives the two row streams and observes the SRAM write port.
// Slave is the writer itself.
interface conv_out_writer_if #(
   parameter int unsigned DATA_W = 25,
   parameter int unsigned ADDR_W = 16
) ();
   logic [DATA_W-1:0] in0;
   logic              in0_valid;
   logic [DATA_W-1:0] in1;
   logic              in1_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in0, in0_valid, in1, in1_valid,
      input  mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in0, in0_valid, in1, in1_valid,
      output mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/conv_out_writer.sv
// conv_out_writer: per pixel, bias-add, optional ReLU, rounding shift and int8 saturation on two
// row lanes. Packs 4 pixels per word per row. Words go through a small queue to a single
// SRAM write port.
module conv_out_writer #(
   parameter int unsigned DATA_W = 25,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned QDEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [7:0]        cfg_width,
   input  logic [7:0]        cfg_rows,
   input  logic [3:0]        cfg_shift,
   input  logic              cfg_relu_en,
   input  logic [15:0]       cfg_bias,
   conv_out_writer_if.slave  bus,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned SUM_W = 26;
   localparam int unsigned PW    = $clog2(QDEPTH);
   localparam int unsigned CW    = PW + 1;
   localparam logic signed [SUM_W:0] QMAX = 127;
   localparam logic signed [SUM_W:0] QMIN = -128;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                  state_q;
   logic [7:0]              width_q, rows_q;
   logic [3:0]              shift_q;
   logic                    relu_q;
   logic [15:0]             bias_q;
   logic [6:0]              wpr_q;
   logic [7:0]              col_q, row_pair_q;
   logic [8:0]              rows_done_q;
   logic [ADDR_W-1:0]       row_base_q;

   logic                    run, take0, take1, lone1;
   logic signed [SUM_W-1:0] bias_ext, sum0, sum1;
   logic [1:0]              s1_valid_q, s2_valid_q;
   logic signed [SUM_W-1:0] s1_sum0_q, s1_sum1_q;
   logic [7:0]              s2_byte0_q, s2_byte1_q;

   logic                    px, last_col, cpl, lane1_ok;
   logic [31:0]             word0, word1, pack0_q, pack1_q;
   logic [ADDR_W-1:0]       col_addr, addr0, addr1;
   logic                    push0_q, push1_q;
   logic [31:0]             word0_q, word1_q;
   logic [ADDR_W-1:0]       addr0_q, addr1_q;

   logic [ADDR_W-1:0]       q_addr [QDEPTH];
   logic [31:0]             q_data [QDEPTH];
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]           count_q, space;
   logic                    pop, acc0, acc1, ovf;
   logic                    start, err_set, pipe_idle;

   // Round-half-up arithmetic shift followed by int8 saturation.
   function automatic logic [7:0] quant(input logic signed [SUM_W-1:0] sum,
                                        input logic [3:0] sh);
      logic signed [SUM_W:0] rnd;
      logic signed [SUM_W:0] v;
      rnd = '0;
      if (sh != 4'd0) rnd[sh - 4'd1] = 1'b1;
      v = ((SUM_W+1)'(sum) + rnd) >>> sh;
      if (v > QMAX) return 8'h7f;
      if (v < QMIN) return 8'h80;
      return v[7:0];
   endfunction

   // Input acceptance and bias/ReLU stage.
   always_comb begin
      run      = state_q == StRun;
      take0    = run && bus.in0_valid;
      take1    = take0 && bus.in1_valid;
      lone1    = run && bus.in1_valid && !bus.in0_valid;
      bias_ext = SUM_W'(signed'(bias_q));
      sum0     = SUM_W'(signed'(bus.in0)) + bias_ext;
      sum1     = SUM_W'(signed'(bus.in1)) + bias_ext;
      if (relu_q && sum0[SUM_W-1]) sum0 = '0;
      if (relu_q && sum1[SUM_W-1]) sum1 = '0;
   end

   // S1 and S2 pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= '0;
         s1_sum0_q  <= '0;
         s1_sum1_q  <= '0;
         s2_valid_q <= '0;
         s2_byte0_q <= '0;
         s2_byte1_q <= '0;
      end else begin
         s1_valid_q <= {take1, take0};
         if (take0) s1_sum0_q <= sum0;
         if (take1) s1_sum1_q <= sum1;
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q[0]) s2_byte0_q <= quant(s1_sum0_q, shift_q);
         if (s1_valid_q[1]) s2_byte1_q <= quant(s1_sum1_q, shift_q);
      end
   end

   // S3: place the byte into its lane word and decide whether the word is complete.
   always_comb begin
      px       = s2_valid_q[0];
      last_col = col_q == (width_q - 8'd1);
      cpl      = px && ((col_q[1:0] == 2'd3) || last_col);
      // The odd row of this pass must exist in the tile.
      lane1_ok = {row_pair_q, 1'b1} < {1'b0, rows_q};
      word0    = pack0_q | ({24'd0, s2_byte0_q} << {col_q[1:0], 3'b000});
      word1    = pack1_q | ({24'd0, s2_byte1_q} << {col_q[1:0], 3'b000});
      col_addr = ADDR_W'(col_q[7:2]);
      addr0    = row_base_q + col_addr;
      addr1    = row_base_q + ADDR_W'(wpr_q) + col_addr;
      start    = (state_q == StIdle) && cfg_start;
   end

   // Lane packers and the enqueue register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack0_q <= '0;
         pack1_q <= '0;
         push0_q <= 1'b0;
         push1_q <= 1'b0;
         word0_q <= '0;
         word1_q <= '0;
         addr0_q <= '0;
         addr1_q <= '0;
      end else begin
         push0_q <= cpl;
         push1_q <= cpl && s2_valid_q[1] && lane1_ok;
         if (cpl) begin
            word0_q <= word0;
            word1_q <= word1;
            addr0_q <= addr0;
            addr1_q <= addr1;
         end
         if (px) pack0_q <= cpl ? '0 : word0;
         if (s2_valid_q[1]) pack1_q <= cpl ? '0 : word1;
         if (start) begin
            pack0_q <= '0;
            pack1_q <= '0;
         end
      end
   end

   // Queue admission: lane0 claims space first; pop frees one slot this cycle.
   always_comb begin
      pop   = count_q != '0;
      space = CW'(QDEPTH) - count_q + CW'(pop);
      acc0  = push0_q && (space != '0);
      acc1  = push1_q && (space > (acc0 ? CW'(1) : CW'(0)));
      ovf   = (push0_q && !acc0) || (push1_q && !acc1);
      err_set   = lone1 || ovf || (cpl && s2_valid_q[1] && !lane1_ok);
      pipe_idle = (s1_valid_q == 2'b00) && (s2_valid_q == 2'b00) && !push0_q && !push1_q;
   end

   // Write queue storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            q_addr[i] <= '0;
            q_data[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (acc0) begin
            q_addr[wr_ptr_q] <= addr0_q;
            q_data[wr_ptr_q] <= word0_q;
         end
         if (acc1) begin
            q_addr[wr_ptr_q + PW'(acc0)] <= addr1_q;
            q_data[wr_ptr_q + PW'(acc0)] <= word1_q;
         end
         wr_ptr_q <= wr_ptr_q + PW'(acc0) + PW'(acc1);
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
      end
   end

   // Registered SRAM write port, draining one queue entry per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.mem_we <= pop;
         if (pop) begin
            bus.mem_addr  <= q_addr[rd_ptr_q];
            bus.mem_wdata <= q_data[rd_ptr_q];
         end
      end
   end

   // Control FSM, tile counters, config latch and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         width_q     <= '0;
         rows_q      <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         bias_q      <= '0;
         wpr_q       <= '0;
         col_q       <= '0;
         row_pair_q  <= '0;
         rows_done_q <= '0;
         row_base_q  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (err_set) err <= 1'b1;
         if (px) begin
            if (last_col) begin
               col_q       <= '0;
               row_pair_q  <= row_pair_q + 8'd1;
               rows_done_q <= rows_done_q + (s2_valid_q[1] ? 9'd2 : 9'd1);
               row_base_q  <= row_base_q + ADDR_W'({wpr_q, 1'b0});
            end else begin
               col_q <= col_q + 8'd1;
            end
         end
         unique case (state_q)
            StIdle: begin
               if (cfg_start) begin
                  width_q     <= cfg_width;
                  rows_q      <= cfg_rows;
                  shift_q     <= cfg_shift;
                  relu_q      <= cfg_relu_en;
                  bias_q      <= cfg_bias;
                  wpr_q       <= 7'(({1'b0, cfg_width} + 9'd3) >> 2);
                  row_base_q  <= cfg_base_addr;
                  col_q       <= '0;
                  row_pair_q  <= '0;
                  rows_done_q <= '0;
                  err         <= 1'b0;
                  busy        <= 1'b1;
                  state_q     <= StRun;
               end
            end
            StRun: begin
               if (rows_done_q >= {1'b0, rows_q}) state_q <= StDrain;
            end
            StDrain: begin
               if ((count_q == '0) && pipe_idle) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
